// File: rtl/sc_level_timer.sv
// Level timer: prescaled one-cycle LOAD ticks, a level counter and a speed band derived from it.
// Pause support is compiled in only when SC_LEVEL_TIMER_PAUSE_EN is defined.
module sc_level_timer #(
   parameter int unsigned PERIOD_0        = 32'd17500000,
   parameter int unsigned PERIOD_1        = 32'd15000000,
   parameter int unsigned PERIOD_2        = 32'd12500000,
   parameter int unsigned LOADS_PER_LEVEL = 32'd32,
   parameter int unsigned LEVEL_MAX       = 32'd59
) (
   input  logic       SC_LEVEL_TIMER_CLOCK_50,
   input  logic       SC_LEVEL_TIMER_RESET_InHigh,
   input  logic       SC_LEVEL_TIMER_START_InLow,
   input  logic       SC_LEVEL_TIMER_PAUSE_InHigh,
   output logic       SC_LEVEL_TIMER_LOAD_OutHigh,
   output logic [7:0] SC_LEVEL_TIMER_LEVEL_Out,
   output logic [1:0] SC_LEVEL_TIMER_BAND_Out,
   output logic       SC_LEVEL_TIMER_DONE_OutHigh
);

   localparam int unsigned PrescW = 25;
   localparam int unsigned CntW   = (LOADS_PER_LEVEL > 1) ? $clog2(LOADS_PER_LEVEL) : 1;

   localparam logic [PrescW-1:0] Reload0   = PrescW'(PERIOD_0 - 1);
   localparam logic [PrescW-1:0] Reload1   = PrescW'(PERIOD_1 - 1);
   localparam logic [PrescW-1:0] Reload2   = PrescW'(PERIOD_2 - 1);
   localparam logic [CntW-1:0]   CntLast   = CntW'(LOADS_PER_LEVEL - 1);
   localparam logic [7:0]        LevelLast = 8'(LEVEL_MAX);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [PrescW-1:0]   presc_q, presc_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [7:0]          level_q, level_d;
   logic                load_fire;

`ifdef SC_LEVEL_TIMER_PAUSE_EN
   logic pause_req;
   assign pause_req = SC_LEVEL_TIMER_PAUSE_InHigh;
`else
   logic unused_pause;
   assign unused_pause = SC_LEVEL_TIMER_PAUSE_InHigh;
`endif

   function automatic logic [1:0] band_of(input logic [7:0] lvl);
      if (lvl <= 8'd10) begin
         return 2'd0;
      end else if (lvl <= 8'd32) begin
         return 2'd1;
      end
      return 2'd2;
   endfunction

   function automatic logic [PrescW-1:0] reload_of(input logic [1:0] band);
      case (band)
         2'd0:    return Reload0;
         2'd1:    return Reload1;
         default: return Reload2;
      endcase
   endfunction

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      load_fire = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (!SC_LEVEL_TIMER_START_InLow) begin
               state_d = StRun;
               presc_d = Reload0;
               cnt_d   = '0;
               level_d = '0;
            end
         end
         StRun: begin
`ifdef SC_LEVEL_TIMER_PAUSE_EN
            if (pause_req) begin
               // Freeze everything, including a prescaler already at zero.
               state_d = StPause;
            end else
`endif
            if (presc_q != '0) begin
               presc_d = presc_q - 1'b1;
            end else begin
               load_fire = 1'b1;
               if (cnt_q == CntLast) begin
                  cnt_d = '0;
                  if (level_q >= LevelLast) begin
                     state_d = StDone;
                  end else begin
                     level_d = level_q + 8'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               // Reload uses the band of the level that follows this LOAD.
               presc_d = reload_of(band_of(level_d));
            end
         end
`ifdef SC_LEVEL_TIMER_PAUSE_EN
         StPause: begin
            if (!pause_req) begin
               state_d = StRun;
            end
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge SC_LEVEL_TIMER_CLOCK_50) begin
      if (SC_LEVEL_TIMER_RESET_InHigh) begin
         state_q <= StIdle;
         presc_q <= '0;
         cnt_q   <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign SC_LEVEL_TIMER_LOAD_OutHigh = load_fire & ~SC_LEVEL_TIMER_RESET_InHigh;
   assign SC_LEVEL_TIMER_LEVEL_Out    = level_q;
   assign SC_LEVEL_TIMER_BAND_Out     = band_of(level_q);
   assign SC_LEVEL_TIMER_DONE_OutHigh = (state_q == StDone);

endmodule

// File: tb/tb_sc_level_timer.sv
// Directed bench for sc_level_timer: start-up vector table plus multi-cycle level/pause/reset runs.
module tb_sc_level_timer;

   localparam int unsigned P0    = 5;
   localparam int unsigned P1    = 4;
   localparam int unsigned P2    = 3;
   localparam int unsigned LPL   = 2;
   localparam int unsigned LMAX  = 12;
   localparam int unsigned LMAX2 = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_n, pause, hold2, sel;
   logic load1, done1, load2, done2;
   logic [7:0] level1, level2;
   logic [1:0] band1, band2;
   logic o_load, o_done;
   logic [7:0] o_level;
   logic [1:0] o_band;

   int n_cmp = 0;
   int n_bad = 0;
   int m_level, m_cnt;
   bit m_done;

   sc_level_timer #(
      .PERIOD_0(P0), .PERIOD_1(P1), .PERIOD_2(P2), .LOADS_PER_LEVEL(LPL), .LEVEL_MAX(LMAX)
   ) dut1 (
      .SC_LEVEL_TIMER_CLOCK_50    (clk),
      .SC_LEVEL_TIMER_RESET_InHigh(rst),
      .SC_LEVEL_TIMER_START_InLow (start_n),
      .SC_LEVEL_TIMER_PAUSE_InHigh(pause),
      .SC_LEVEL_TIMER_LOAD_OutHigh(load1),
      .SC_LEVEL_TIMER_LEVEL_Out   (level1),
      .SC_LEVEL_TIMER_BAND_Out    (band1),
      .SC_LEVEL_TIMER_DONE_OutHigh(done1)
   );

   sc_level_timer #(
      .PERIOD_0(P0), .PERIOD_1(P1), .PERIOD_2(P2), .LOADS_PER_LEVEL(LPL), .LEVEL_MAX(LMAX2)
   ) dut2 (
      .SC_LEVEL_TIMER_CLOCK_50    (clk),
      .SC_LEVEL_TIMER_RESET_InHigh(rst | hold2),
      .SC_LEVEL_TIMER_START_InLow (start_n),
      .SC_LEVEL_TIMER_PAUSE_InHigh(pause),
      .SC_LEVEL_TIMER_LOAD_OutHigh(load2),
      .SC_LEVEL_TIMER_LEVEL_Out   (level2),
      .SC_LEVEL_TIMER_BAND_Out    (band2),
      .SC_LEVEL_TIMER_DONE_OutHigh(done2)
   );

   assign o_load  = sel ? load2  : load1;
   assign o_done  = sel ? done2  : done1;
   assign o_level = sel ? level2 : level1;
   assign o_band  = sel ? band2  : band1;

   typedef struct {
      logic r;
      logic s;
      logic p;
      logic load;
      int   level;
      logic done;
   } vec_t;

   function automatic int band_of(input int lvl);
      if (lvl <= 10) return 0;
      if (lvl <= 32) return 1;
      return 2;
   endfunction

   function automatic int period_of(input int lvl);
      case (band_of(lvl))
         0:       return P0;
         1:       return P1;
         default: return P2;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1 ns later.
   task automatic drive(input logic r, input logic s, input logic p);
      rst = r;
      start_n = s;
      pause = p;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Measures LOAD spacing per level against the model until done or stop_lvl is reached.
   task automatic run_loads(input int lmax, input int stop_lvl, input logic p);
      int  gap;
      bit  seen;
      while (!m_done && m_level < stop_lvl) begin
         gap  = 0;
         seen = 1'b0;
         do begin
            drive(1'b0, (m_level >= 2 && m_level <= 4) ? 1'b0 : 1'b1, p);
            gap++;
            seen = o_load;
            if (seen) begin
               chk($sformatf("gap_lvl%0d", m_level), gap, period_of(m_level));
               chk($sformatf("level_at_load%0d", m_level), int'(o_level), m_level);
               chk($sformatf("band_at_load%0d", m_level), int'(o_band), band_of(m_level));
               chk("done_in_run", int'(o_done), 0);
            end
            tick();
         end while (!seen && gap < 64);
         if (!seen) begin
            chk("load_timeout", gap, period_of(m_level));
            return;
         end
         m_cnt++;
         if (m_cnt == LPL) begin
            m_cnt = 0;
            if (m_level == lmax) m_done = 1'b1;
            else m_level++;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[12];
      int   n_load;

      tbl[0]  = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[1]  = '{r: 1'b0, s: 1'b0, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[2]  = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[3]  = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[4]  = '{r: 1'b0, s: 1'b0, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[5]  = '{r: 1'b0, s: 1'b0, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[6]  = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b1, level: 0, done: 1'b0};
      tbl[7]  = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[8]  = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[9]  = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[10] = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b0, level: 0, done: 1'b0};
      tbl[11] = '{r: 1'b0, s: 1'b1, p: 1'b0, load: 1'b1, level: 0, done: 1'b0};

      rst = 1'b1; start_n = 1'b1; pause = 1'b0; hold2 = 1'b1; sel = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      drive(1'b1, 1'b0, 1'b0);
      chk("reset_load", int'(o_load), 0);
      chk("reset_level", int'(o_level), 0);
      chk("reset_done", int'(o_done), 0);
      chk("reset_band", int'(o_band), 0);
      tick();

      // Start-up: first LOAD five cycles after the start edge, second one five later.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].r, tbl[i].s, tbl[i].p);
         chk($sformatf("vec%0d_load", i), int'(o_load), int'(tbl[i].load));
         chk($sformatf("vec%0d_level", i), int'(o_level), tbl[i].level);
         chk($sformatf("vec%0d_done", i), int'(o_done), int'(tbl[i].done));
         tick();
      end

      // Run to DONE, checking spacing and band at every LOAD.
      m_level = 1; m_cnt = 0; m_done = 1'b0;
      run_loads(LMAX, 255, 1'b0);
      chk("reached_done", int'(m_done), 1);
      n_load = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         chk("done_flag", int'(o_done), 1);
         chk("done_level", int'(o_level), LMAX);
         n_load += int'(o_load);
         tick();
      end
      chk("done_no_load", n_load, 0);

      // Restart from DONE, then reset mid-RUN at level 3 on a prescaler-zero cycle.
      drive(1'b0, 1'b0, 1'b0);
      chk("done_before_restart", int'(o_done), 1);
      tick();
      m_level = 0; m_cnt = 0; m_done = 1'b0;
      run_loads(LMAX, 3, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      chk("level3_reached", int'(o_level), 3);
      tick();
      repeat (3) begin
         drive(1'b0, 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 1'b0);
      chk("reset_cycle_no_load", int'(o_load), 0);
      tick();
      drive(1'b0, 1'b1, 1'b0);
      chk("post_reset_level", int'(o_level), 0);
      chk("post_reset_load", int'(o_load), 0);
      chk("post_reset_done", int'(o_done), 0);
      tick();
      n_load = 0;
      repeat (8) begin
         drive(1'b0, 1'b1, 1'b0);
         n_load += int'(o_load);
         tick();
      end
      chk("idle_no_load", n_load, 0);

      // Pause over the prescaler-zero cycle.
      drive(1'b0, 1'b0, 1'b0);
      tick();
      n_load = 0;
`ifdef SC_LEVEL_TIMER_PAUSE_EN
      repeat (4) begin
         drive(1'b0, 1'b1, 1'b0);
         n_load += int'(o_load);
         tick();
      end
      repeat (7) begin
         drive(1'b0, 1'b1, 1'b1);
         n_load += int'(o_load);
         tick();
      end
      drive(1'b0, 1'b1, 1'b0);
      n_load += int'(o_load);
      tick();
      chk("pause_no_load", n_load, 0);
      drive(1'b0, 1'b1, 1'b0);
      chk("load_after_release", int'(o_load), 1);
      chk("pause_level_kept", int'(o_level), 0);
      tick();
      m_level = 0; m_cnt = 1; m_done = 1'b0;
      run_loads(LMAX, 1, 1'b0);
`else
      repeat (4) begin
         drive(1'b0, 1'b1, 1'b1);
         n_load += int'(o_load);
         tick();
      end
      chk("pause_ignored_early", n_load, 0);
      drive(1'b0, 1'b1, 1'b1);
      chk("pause_ignored_load", int'(o_load), 1);
      chk("pause_ignored_level", int'(o_level), 0);
      tick();
      m_level = 0; m_cnt = 1; m_done = 1'b0;
      run_loads(LMAX, 2, 1'b1);
`endif
      chk("pause_seq_level", int'(m_level), int'(o_level));

      // LEVEL_MAX=40 instance: band 2 from level 33 with spacing 3.
      sel = 1'b1;
      hold2 = 1'b0;
      drive(1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0);
      chk("dut2_reset_level", int'(o_level), 0);
      chk("dut2_reset_done", int'(o_done), 0);
      tick();
      drive(1'b0, 1'b0, 1'b0);
      tick();
      m_level = 0; m_cnt = 0; m_done = 1'b0;
      run_loads(LMAX2, 34, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      chk("dut2_level34", int'(o_level), 34);
      chk("dut2_band2", int'(o_band), 2);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sc_level_timer.md
SC_LEVEL_TIMER -- requirements
Module: SC_LEVEL_TIMER

Interface
REQ-001 Parameter PERIOD_0, default 17500000: LOAD period in clocks for band 0 (0.35 s at 50 MHz).
REQ-002 Parameter PERIOD_1, default 15000000: LOAD period in clocks for band 1 (0.30 s).
REQ-003 Parameter PERIOD_2, default 12500000: LOAD period in clocks for band 2 (0.25 s).
REQ-004 Parameter LOADS_PER_LEVEL, default 32: LOAD pulses per level.
REQ-005 Parameter LEVEL_MAX, default 59: final level.
REQ-006 SC_LEVEL_TIMER_CLOCK_50  in  1  system clock; one clock, all logic on its rising edge.
REQ-007 SC_LEVEL_TIMER_RESET_InHigh  in  1  reset, synchronous, active-high.
REQ-008 SC_LEVEL_TIMER_START_InLow  in  1  start request, active-low, level-sampled.
REQ-009 SC_LEVEL_TIMER_PAUSE_InHigh  in  1  pause request.
REQ-010 SC_LEVEL_TIMER_LOAD_OutHigh  out  1  one-cycle load tick to the downstream game state machine.
REQ-011 SC_LEVEL_TIMER_LEVEL_Out  out  8  current level, 0..LEVEL_MAX.
REQ-012 SC_LEVEL_TIMER_BAND_Out  out  2  speed band, usable as mux select: 0, 1 or 2.
REQ-013 SC_LEVEL_TIMER_DONE_OutHigh  out  1  high while in DONE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, all registered.
REQ-015 In IDLE, START_InLow=0 SHALL cause a transition to RUN, clear the level and load counts, and load the prescaler with PERIOD_0-1.
REQ-016 In RUN, the prescaler SHALL decrement once per clock; at 0, LOAD SHALL be high for that cycle and the prescaler SHALL reload with PERIOD_band-1 for the level in effect after that LOAD.
REQ-017 The first LOAD SHALL occur in the PERIOD_0-th cycle after the START-sampling edge; later LOADs SHALL occur exactly PERIOD_band cycles apart.
REQ-018 Each LOAD SHALL increment the load count; a LOAD with load count = LOADS_PER_LEVEL-1 SHALL clear the count and increment the level.
REQ-019 Band SHALL be 0 for level 0..10, 1 for level 11..32, and 2 for level 33..LEVEL_MAX; band is combinational from the registered level.
REQ-020 The final LOAD of level LEVEL_MAX SHALL cause a transition to DONE; the level SHALL hold at LEVEL_MAX and never wrap.
REQ-021 In DONE, LOAD SHALL be 0 and DONE_OutHigh 1; START_InLow=0 SHALL restart as in REQ-015.
REQ-022 In RUN, START_InLow SHALL be ignored.
REQ-023 In RUN, PAUSE_InHigh=1 SHALL cause a transition to PAUSE, with prescaler, counts and level frozen.
REQ-024 If PAUSE_InHigh=1 in the cycle the prescaler is 0, no LOAD SHALL occur; the prescaler holds at 0 and LOAD fires in the first RUN cycle after release.
REQ-025 In PAUSE, PAUSE_InHigh=0 SHALL cause a return to RUN; LOAD SHALL be 0 throughout PAUSE.
REQ-026 Prescaler width SHALL be 25 bits; every parameter value SHALL fit without truncation.

Reset
REQ-027 RESET_InHigh=1 at a clock edge SHALL force IDLE, prescaler 0, counts 0, LEVEL 0, LOAD 0 and DONE 0, overriding all other inputs.
REQ-028 Reset asserted mid-RUN or mid-PAUSE SHALL abort with no LOAD in the reset cycle.

Configuration
REQ-029 Macro SC_LEVEL_TIMER_PAUSE_EN defined: PAUSE state and REQ-023..025 SHALL be compiled in.
REQ-030 Macro SC_LEVEL_TIMER_PAUSE_EN undefined: the PAUSE_InHigh port SHALL remain but be ignored, PAUSE SHALL be unreachable, and RUN counts continuously.

Verification
Use PERIOD_0=5, PERIOD_1=4, PERIOD_2=3, LOADS_PER_LEVEL=2 and LEVEL_MAX=12 unless noted.
REQ-031 Reset, then START_InLow=0 for 1 cycle -> first LOAD exactly 5 cycles later, then every 5 cycles; LEVEL increments after every 2nd LOAD.
REQ-032 Run to level 11 -> BAND goes 0->1 and LOAD spacing becomes 4 from the reload at that LOAD; at level 12, the second LOAD -> DONE=1, LEVEL stays 12, no further LOAD.
REQ-033 With LEVEL_MAX=40, reach level 33 -> BAND=2 and spacing becomes 3.
REQ-034 PAUSE_InHigh=1 for 7 cycles, coincident with prescaler=0 -> no LOAD during pause; LOAD in first cycle after release; LEVEL unchanged.
REQ-035 RESET_InHigh=1 mid-RUN at level 3 -> next cycle IDLE, LEVEL=0, LOAD=0; START_InLow held 0 during RUN -> no restart.
REQ-036 Macro undefined, PAUSE_InHigh=1 throughout -> LOAD cadence identical to REQ-031.
